// File: rtl/serial_rx.sv
// serial_rx: 8N1 asynchronous serial receiver, LSB first.
// Bit timing comes from an external baud generator as single-cycle ticks:
// the half-bit tick centres on the start bit, the full-bit tick samples
// the data and stop bits. One good frame yields one ready_o strobe.
module serial_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  sysclk,
  input  logic                  reset_n,
  input  logic                  half_baud_rate_tick_i,
  input  logic                  baud_rate_tick_i,
  input  logic                  recieve_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  ready_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  // Entered after a framing error; the line must return high before
  // IDLE may look for a new start edge, so a held break cannot retrigger.
  localparam logic [2:0] BRK   = 3'd4;

  logic                  rx_meta;
  logic                  rx_s;
  logic [2:0]            state;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= recieve_i;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM with bit counter, right-shifting deserialiser and output register.
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
      data_o  <= '0;
      ready_o <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) state <= START;
        end
        START: begin
          if (half_baud_rate_tick_i) begin
            if (!rx_s) begin
              bit_cnt <= '0;
              state   <= DATA;
            end else begin
              state   <= IDLE;
            end
          end
        end
        DATA: begin
          if (baud_rate_tick_i) begin
            // New bit enters at the MSB so the first bit lands in bit 0.
            shift   <= {rx_s, shift[DATA_WIDTH-1:1]};
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == CW'(DATA_WIDTH - 1)) state <= STOP;
          end
        end
        STOP: begin
          if (baud_rate_tick_i) begin
            if (rx_s) begin
              data_o  <= shift;
              ready_o <= 1'b1;
              state   <= IDLE;
            end else begin
              state   <= BRK;
            end
          end
        end
        BRK: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: directed frames with a scoreboard. The stimulus pushes
// each byte expected to be delivered; a monitor pops and compares on every
// ready_o strobe, and also checks data_o holds between strobes.
module tb_serial_rx;

  logic       sysclk = 1'b0;
  logic       reset_n = 1'b0;
  logic       half_tick = 1'b0;
  logic       baud_tick = 1'b0;
  logic       line = 1'b1;
  logic [7:0] data_o;
  logic       ready_o;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] hold_val = 8'h00;
  logic       prev_ready = 1'b0;

  always #5 sysclk = ~sysclk;

  serial_rx #(.DATA_WIDTH(8)) dut (
    .sysclk               (sysclk),
    .reset_n              (reset_n),
    .half_baud_rate_tick_i(half_tick),
    .baud_rate_tick_i     (baud_tick),
    .recieve_i            (line),
    .data_o               (data_o),
    .ready_o              (ready_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pop on ready_o, single-cycle strobe, data_o hold.
  always @(negedge sysclk) begin
    if (reset_n) begin
      if (ready_o) begin
        check("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ready: got data %0h expected no strobe at %0t", data_o, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("rx_byte", {24'd0, data_o}, {24'd0, e});
          hold_val = e;
        end
      end else begin
        check("data_hold", {24'd0, data_o}, {24'd0, hold_val});
      end
    end
    prev_ready = ready_o;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // One 16-cycle bit period per bit; ticks land mid-bit (cycle 8).
  // nbits < 8 stops early without a stop bit (used for the abort case).
  task automatic frame(input logic [7:0] b, input logic stop, input logic both, input int nbits);
    line = 1'b0;
    cyc(8);
    half_tick = 1'b1; baud_tick = both;
    cyc(1);
    half_tick = 1'b0; baud_tick = 1'b0;
    cyc(7);
    for (int i = 0; i < nbits; i++) begin
      line = b[i];
      cyc(8);
      baud_tick = 1'b1; half_tick = both;
      cyc(1);
      baud_tick = 1'b0; half_tick = 1'b0;
      cyc(7);
    end
    if (nbits == 8) begin
      line = stop;
      cyc(8);
      baud_tick = 1'b1; half_tick = both;
      cyc(1);
      baud_tick = 1'b0; half_tick = 1'b0;
    end
  endtask

  initial begin
    cyc(3);
    @(negedge sysclk);
    check("reset_data", {24'd0, data_o}, 32'd0);
    check("reset_ready", {31'd0, ready_o}, 32'd0);
    @(posedge sysclk); #1;
    reset_n = 1'b1;
    cyc(4);

    // 0x55 with clean timing
    exp_q.push_back(8'h55);
    frame(8'h55, 1'b1, 1'b0, 8);
    cyc(20);
    check("hold_55", {24'd0, data_o}, 32'h55);

    // 0xA5 then 0x00 back-to-back
    exp_q.push_back(8'hA5);
    frame(8'hA5, 1'b1, 1'b0, 8);
    exp_q.push_back(8'h00);
    frame(8'h00, 1'b1, 1'b0, 8);
    cyc(20);
    check("hold_00", {24'd0, data_o}, 32'h00);

    // Reload a nonzero value so later "unchanged" checks are meaningful
    exp_q.push_back(8'h5A);
    frame(8'h5A, 1'b1, 1'b0, 8);
    cyc(20);

    // Short glitch: line high again before the half tick
    line = 1'b0;
    cyc(3);
    line = 1'b1;
    cyc(5);
    half_tick = 1'b1; cyc(1); half_tick = 1'b0;
    cyc(40);
    check("glitch_data", {24'd0, data_o}, 32'h5A);

    // 0x3C with a zero stop bit, then a held break with ticks running.
    // A block that retriggered from the break would complete a 0x00 frame
    // when the line finally rises on the last tick.
    frame(8'h3C, 1'b0, 1'b0, 8);
    cyc(16);
    half_tick = 1'b1; cyc(1); half_tick = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(15);
      baud_tick = 1'b1; cyc(1); baud_tick = 1'b0;
    end
    line = 1'b1;
    cyc(8);
    baud_tick = 1'b1; cyc(1); baud_tick = 1'b0;
    cyc(20);
    check("framing_data", {24'd0, data_o}, 32'h5A);

    // Both ticks every period during 0xC3
    exp_q.push_back(8'hC3);
    frame(8'hC3, 1'b1, 1'b1, 8);
    cyc(20);
    check("hold_C3", {24'd0, data_o}, 32'hC3);

    // Reset after 4 data bits of 0xFF, then a clean 0x81
    frame(8'hFF, 1'b1, 1'b0, 4);
    reset_n = 1'b0;
    hold_val = 8'h00;
    @(negedge sysclk);
    check("midreset_data", {24'd0, data_o}, 32'd0);
    check("midreset_ready", {31'd0, ready_o}, 32'd0);
    cyc(3);
    reset_n = 1'b1;
    // Finish the aborted frame's remaining bits and stop without ticks
    cyc(80);
    exp_q.push_back(8'h81);
    frame(8'h81, 1'b1, 1'b0, 8);
    cyc(20);
    check("hold_81", {24'd0, data_o}, 32'h81);

    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
